// File: rtl/spi_rx_deserializer.sv
// SPI mode-0 receive deserializer: synchronizes the asynchronous SPI pins into
// the sclk domain, assembles MSB-first words and offers them on a valid/ready port.
module spi_rx_deserializer #(
  parameter int WORD_BITS   = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 sclk,
  input  logic                 reset,
  input  logic                 spi_sck,
  input  logic                 spi_mosi,
  input  logic                 spi_cs_n,
  output logic [WORD_BITS-1:0] Data,
  output logic                 i_SPI_valid,
  input  logic                 o_SPI_ready,
  output logic                 overrun,
  output logic                 frame_err
);

  localparam int CNT_W = $clog2(WORD_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sck_prev;

  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [WORD_BITS-2:0]   r_shift;
  logic [WORD_BITS-1:0]   r_data;
  logic                   r_valid;
  logic                   r_overrun;
  logic                   r_frame_err;

  logic                   w_sck;
  logic                   w_mosi;
  logic                   w_cs_n;
  logic                   w_edge;
  logic [WORD_BITS-1:0]   w_word;
  logic                   w_xfer;
  logic                   w_done;
  logic                   w_load;

  // Synchronizers reset to 1 so an idle-low sck never looks like a rising edge.
  always_ff @(posedge sclk) begin
    if (reset) begin
      r_sck_sync  <= '1;
      r_mosi_sync <= '1;
      r_cs_sync   <= '1;
      r_sck_prev  <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_sck_prev  <= w_sck;
    end
  end

  assign w_sck  = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_n = r_cs_sync[SYNC_STAGES-1];
  assign w_edge = w_sck & ~r_sck_prev;

  assign w_word = {r_shift, w_mosi};
  assign w_xfer = r_valid & o_SPI_ready;
  assign w_done = (r_state == S_SHIFT) && !w_cs_n && w_edge && (r_cnt == LAST_BIT);
  // A completed word may take the output slot if it is empty or draining this cycle.
  assign w_load = w_done && (!r_valid || w_xfer);

  always_ff @(posedge sclk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_cs_n) r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (w_cs_n) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_state <= (r_valid && !w_xfer) ? S_HOLD : S_IDLE;
          end else if (w_edge) begin
            r_shift <= w_word[WORD_BITS-2:0];
            r_cnt   <= (r_cnt == LAST_BIT) ? '0 : r_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (!w_cs_n)     r_state <= S_SHIFT;
          else if (w_xfer) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output slot and sticky status flags; a dropped word never disturbs the held one.
  always_ff @(posedge sclk) begin
    if (reset) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_load) begin
        r_data  <= w_word;
        r_valid <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
      if (w_done && !w_load) r_overrun <= 1'b1;
      if ((r_state == S_SHIFT) && w_cs_n && (r_cnt != '0)) r_frame_err <= 1'b1;
    end
  end

  assign Data        = r_data;
  assign i_SPI_valid = r_valid;
  assign overrun     = r_overrun;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_spi_rx_deserializer.sv
// Directed bench for spi_rx_deserializer: table of single-word frames plus
// hand-written overrun, same-cycle handshake, framing, reset and hold sequences.
module tb_spi_rx_deserializer;

  logic       sclk = 1'b0;
  logic       reset;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_cs_n;
  logic [8:0] Data;
  logic       i_SPI_valid;
  logic       o_SPI_ready;
  logic       overrun;
  logic       frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] xq[$];

  spi_rx_deserializer #(.WORD_BITS(9), .SYNC_STAGES(2)) dut (
    .sclk        (sclk),
    .reset       (reset),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_cs_n    (spi_cs_n),
    .Data        (Data),
    .i_SPI_valid (i_SPI_valid),
    .o_SPI_ready (o_SPI_ready),
    .overrun     (overrun),
    .frame_err   (frame_err)
  );

  always #5 sclk = ~sclk;

  // Transfer log: a word moves when valid and ready are both high at the coming edge.
  always @(negedge sclk) begin
    if (!reset && i_SPI_valid && o_SPI_ready) xq.push_back(Data);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [8:0]  word;
    logic        cs_active;
    int          exp_xfers;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sclk);
      #1;
    end
  endtask

  function automatic logic [31:0] xq_at(input int idx);
    if (xq.size() > idx) return {23'd0, xq[idx]};
    return 32'hDEAD;
  endfunction

  // Sends nbits MSB-first at sclk/8; with pulse set, ready is raised for exactly
  // the cycle in which the final rising edge is detected (two cycles of sync delay).
  task automatic send_word(input logic [8:0] w, input int nbits, input bit pulse);
    for (int b = 8; b > 8 - nbits; b--) begin
      spi_sck  = 1'b0;
      spi_mosi = w[b];
      tick(4);
      spi_sck = 1'b1;
      if (pulse && b == 0) begin
        tick(2);
        check("pulse_pre_valid", {31'd0, i_SPI_valid}, 32'd1);
        o_SPI_ready = 1'b1;
        tick(1);
        o_SPI_ready = 1'b0;
        check("pulse_post_valid", {31'd0, i_SPI_valid}, 32'd1);
        check("pulse_post_data", {23'd0, Data}, {23'd0, w});
        tick(1);
      end else begin
        tick(4);
      end
    end
    spi_sck = 1'b0;
    tick(4);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(4);
  endtask

  initial begin
    int bad;
    tbl[0] = '{word: 9'h1A5, cs_active: 1'b1, exp_xfers: 1, exp_data: 32'h1A5};
    tbl[1] = '{word: 9'h000, cs_active: 1'b1, exp_xfers: 1, exp_data: 32'h000};
    tbl[2] = '{word: 9'h1FF, cs_active: 1'b1, exp_xfers: 1, exp_data: 32'h1FF};
    tbl[3] = '{word: 9'h0AA, cs_active: 1'b1, exp_xfers: 1, exp_data: 32'h0AA};
    tbl[4] = '{word: 9'h155, cs_active: 1'b1, exp_xfers: 1, exp_data: 32'h155};
    tbl[5] = '{word: 9'h0F0, cs_active: 1'b0, exp_xfers: 0, exp_data: 32'hDEAD};

    reset       = 1'b1;
    spi_sck     = 1'b0;
    spi_mosi    = 1'b0;
    spi_cs_n    = 1'b1;
    o_SPI_ready = 1'b0;
    tick(3);
    check("rst_data", {23'd0, Data}, 32'd0);
    check("rst_valid", {31'd0, i_SPI_valid}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    reset = 1'b0;
    tick(4);

    // Single-word frames with ready held high; last entry toggles sck with cs_n high.
    for (int i = 0; i < 6; i++) begin
      xq.delete();
      o_SPI_ready = 1'b1;
      spi_cs_n = !tbl[i].cs_active;
      tick(4);
      send_word(tbl[i].word, 9, 1'b0);
      spi_cs_n = 1'b1;
      tick(8);
      check("tbl_xfers", xq.size(), tbl[i].exp_xfers);
      check("tbl_data", xq_at(0), tbl[i].exp_data);
      check("tbl_overrun", {31'd0, overrun}, 32'd0);
      check("tbl_frame_err", {31'd0, frame_err}, 32'd0);
    end

    // Ready asserted only in the cycle the second word loads.
    xq.delete();
    o_SPI_ready = 1'b0;
    spi_cs_n = 1'b0;
    tick(4);
    send_word(9'h0A3, 9, 1'b0);
    send_word(9'h15C, 9, 1'b1);
    spi_cs_n = 1'b1;
    tick(4);
    o_SPI_ready = 1'b1;
    tick(6);
    check("sameclk_count", xq.size(), 32'd2);
    check("sameclk_first", xq_at(0), 32'h0A3);
    check("sameclk_second", xq_at(1), 32'h15C);
    check("sameclk_overrun", {31'd0, overrun}, 32'd0);

    // Pending word survives cs_n deassertion while ready stays low.
    xq.delete();
    o_SPI_ready = 1'b0;
    spi_cs_n = 1'b0;
    tick(4);
    send_word(9'h1C3, 9, 1'b0);
    spi_cs_n = 1'b1;
    bad = 0;
    repeat (20) begin
      tick(1);
      if (i_SPI_valid !== 1'b1 || Data !== 9'h1C3) bad++;
    end
    check("hold_stable_bad_cycles", bad, 32'd0);
    check("hold_no_early_xfer", xq.size(), 32'd0);
    o_SPI_ready = 1'b1;
    tick(4);
    check("hold_xfer_count", xq.size(), 32'd1);
    check("hold_xfer_data", xq_at(0), 32'h1C3);
    check("hold_valid_drop", {31'd0, i_SPI_valid}, 32'd0);

    // Three back-to-back words with ready low: first held, rest dropped.
    xq.delete();
    o_SPI_ready = 1'b0;
    spi_cs_n = 1'b0;
    tick(4);
    send_word(9'h0FF, 9, 1'b0);
    send_word(9'h100, 9, 1'b0);
    send_word(9'h055, 9, 1'b0);
    spi_cs_n = 1'b1;
    tick(8);
    check("ovr_data_held", {23'd0, Data}, 32'h0FF);
    check("ovr_valid", {31'd0, i_SPI_valid}, 32'd1);
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    check("ovr_no_xfer", xq.size(), 32'd0);
    o_SPI_ready = 1'b1;
    tick(6);
    check("ovr_xfer_count", xq.size(), 32'd1);
    check("ovr_xfer_data", xq_at(0), 32'h0FF);
    check("ovr_valid_drop", {31'd0, i_SPI_valid}, 32'd0);
    check("ovr_sticky", {31'd0, overrun}, 32'd1);
    check("ovr_frame_err", {31'd0, frame_err}, 32'd0);

    do_reset();
    check("ovr_clr_by_reset", {31'd0, overrun}, 32'd0);

    // cs_n rises after 5 bits, then a clean word.
    xq.delete();
    o_SPI_ready = 1'b1;
    spi_cs_n = 1'b0;
    tick(4);
    send_word(9'h0AB, 5, 1'b0);
    spi_cs_n = 1'b1;
    tick(8);
    check("ferr_flag", {31'd0, frame_err}, 32'd1);
    check("ferr_no_xfer", xq.size(), 32'd0);
    check("ferr_valid", {31'd0, i_SPI_valid}, 32'd0);
    spi_cs_n = 1'b0;
    tick(4);
    send_word(9'h03C, 9, 1'b0);
    spi_cs_n = 1'b1;
    tick(8);
    check("ferr_next_count", xq.size(), 32'd1);
    check("ferr_next_data", xq_at(0), 32'h03C);
    check("ferr_sticky", {31'd0, frame_err}, 32'd1);

    do_reset();

    // One-cycle reset after bit 4 of a word, then a fresh word.
    xq.delete();
    o_SPI_ready = 1'b1;
    spi_cs_n = 1'b0;
    tick(4);
    send_word(9'h0B7, 4, 1'b0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(4);
    send_word(9'h1FE, 9, 1'b0);
    spi_cs_n = 1'b1;
    tick(8);
    check("midrst_count", xq.size(), 32'd1);
    check("midrst_data", xq_at(0), 32'h1FE);
    check("midrst_overrun", {31'd0, overrun}, 32'd0);
    check("midrst_frame_err", {31'd0, frame_err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_rx_deserializer.md
SPI_RX_DESERIALIZER -- requirements
Module: spi_rx_deserializer

Interface
REQ-001 Parameter WORD_BITS, default 9, SHALL set bits per word: bit 8 = D/C mode flag, bits 7:0 = payload byte.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set flip-flop depth of each input synchronizer (legal 2..4).
REQ-003 sclk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 spi_sck  input  1  SHALL be the asynchronous external serial clock, SPI mode 0.
REQ-006 spi_mosi  input  1  SHALL be the asynchronous external serial data line, MSB first.
REQ-007 spi_cs_n  input  1  SHALL be the asynchronous external active-low chip select.
REQ-008 Data  output  WORD_BITS  SHALL carry the assembled word toward the downstream buffer.
REQ-009 i_SPI_valid  output  1  SHALL flag Data as valid; it drives the downstream i_SPI_valid input.
REQ-010 o_SPI_ready  input  1  SHALL be downstream readiness; it receives the downstream o_SPI_ready output.
REQ-011 overrun  output  1  SHALL be a sticky flag, set when a completed word is dropped.
REQ-012 frame_err  output  1  SHALL be a sticky flag, set when cs_n deasserts mid-word.

Function
REQ-013 spi_sck, spi_mosi and spi_cs_n SHALL each pass through SYNC_STAGES flops before use; no other logic SHALL sample them.
REQ-014 A sck rising edge SHALL be detected as: synchronized sck = 1 while its previous-cycle value = 0; sampled mosi SHALL be the synchronized value in that same cycle.
REQ-015 The block SHALL require the sclk frequency to be at least 4x the spi_sck frequency; no behaviour is defined below that ratio.
REQ-016 FSM states SHALL be IDLE, SHIFT and HOLD.
REQ-017 IDLE: bit counter = 0; synchronized cs_n = 0 SHALL move the FSM to SHIFT.
REQ-018 SHIFT: on each detected edge, the shift register SHALL shift left with mosi entering at bit 0, and the counter SHALL increment.
REQ-019 On the edge where the counter reaches WORD_BITS, the shift result SHALL load the output register, and the counter SHALL wrap to 0 with the FSM staying in SHIFT.
REQ-020 Latency: Data/i_SPI_valid SHALL be visible in the sclk cycle after the cycle in which the final edge is detected.
REQ-021 Handshake: a word SHALL transfer in a cycle where i_SPI_valid = 1 and o_SPI_ready = 1; i_SPI_valid SHALL drop the following cycle unless a new word loads in that same cycle.
REQ-022 While i_SPI_valid = 1 and o_SPI_ready = 0, Data SHALL hold stable.
REQ-023 A new word completing while the output register is occupied and not transferring SHALL be discarded, the held word SHALL be kept, and overrun SHALL be set.
REQ-024 A word completing in the same cycle as a transfer SHALL load with no loss, and i_SPI_valid SHALL stay 1.
REQ-025 Synchronized cs_n rising while counter != 0 SHALL discard the partial word, set frame_err and return to IDLE.
REQ-026 Synchronized cs_n rising while counter = 0 SHALL return to IDLE with no flag set.
REQ-027 A pending output word SHALL survive cs_n deassertion; HOLD is the IDLE-equivalent state entered when cs_n deasserts with i_SPI_valid = 1.
REQ-028 HOLD SHALL exit to IDLE when the pending word transfers, or to SHIFT if cs_n asserts first.
REQ-029 sck edges SHALL be ignored in IDLE and HOLD.
REQ-030 overrun and frame_err SHALL clear only by reset.

Reset
REQ-031 While reset = 1 at a sclk edge: FSM = IDLE, counter = 0, shift register = 0, Data = 0, i_SPI_valid = 0, overrun = 0, frame_err = 0, all synchronizer flops = 1 (cs_n high, sck high).
REQ-032 Reset asserted mid-word or with a pending word SHALL discard all data, with no flag set.
REQ-033 The first edge SHALL be detectable no earlier than SYNC_STAGES+1 cycles after reset releases.

Verification
REQ-034 Stimulus: cs_n low, send 9'h1A5 at sclk/8, o_SPI_ready = 1 -> exactly one i_SPI_valid pulse with Data = 9'h1A5, no flags.
REQ-035 Stimulus: back-to-back words 9'h0FF, 9'h100, 9'h055 under one cs_n, ready held 0 until the third completes -> Data = 9'h0FF held, overrun = 1; after ready, one transfer of 9'h0FF, and the later words are not output.
REQ-036 Stimulus: ready pulses exactly in the cycle the second word loads -> both words transfer, i_SPI_valid continuous, overrun = 0.
REQ-037 Stimulus: cs_n rises after 5 bits -> no i_SPI_valid, frame_err = 1; the next full word 9'h03C is received correctly.
REQ-038 Stimulus: reset for 1 cycle after bit 4 of a word, then a fresh word 9'h1FE -> only 9'h1FE output, flags = 0.
REQ-039 Stimulus: cs_n deasserts with a word pending and ready = 0 for 20 cycles -> Data stable, i_SPI_valid = 1 throughout, and the word transfers once ready = 1.
